// File: rtl/mul_div_unit_if.sv
// Command/result bundle between the E-stage decoder and the HI/LO execution unit.
// The master drives commands and operands; the slave returns busy, HI, LO and the selected result.
interface mul_div_unit_if;
  logic [3:0]  mulCtrl;
  logic        mulEnable;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        mulOutputSel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] result;

  modport master (
    output mulCtrl, mulEnable, operandA, operandB, mulOutputSel,
    input  busy, hi, lo, result
  );

  modport slave (
    input  mulCtrl, mulEnable, operandA, operandB, mulOutputSel,
    output busy, hi, lo, result
  );
endinterface

// File: rtl/mul_div_unit.sv
// E-stage HI/LO unit: mult/multu/div/divu/madd/maddu/msub with a fixed busy latency, plus mthi/mtlo.
// Optional MDU_CANCEL_EN adds a cancel input that aborts an in-flight op and blocks acceptance in IDLE.
module mul_div_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic clk,
  input  logic reset_n,
`ifdef MDU_CANCEL_EN
  input  logic cancel,
`endif
  mul_div_unit_if.slave bus
);

  localparam logic [3:0] MT_DISABLED   = 4'd0;
  localparam logic [3:0] MT_MULTIPLY   = 4'd1;
  localparam logic [3:0] MT_MULTIPLY_U = 4'd2;
  localparam logic [3:0] MT_DIVIDE     = 4'd3;
  localparam logic [3:0] MT_DIVIDE_U   = 4'd4;
  localparam logic [3:0] MT_MADD       = 4'd5;
  localparam logic [3:0] MT_MADDU      = 4'd6;
  localparam logic [3:0] MT_MSUB       = 4'd7;
  localparam logic [3:0] MT_SET_HI     = 4'd8;
  localparam logic [3:0] MT_SET_LO     = 4'd9;

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MUL_N = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, stateNext;
  logic [CW-1:0]  count, countNext;
  logic [63:0]    pending, pendingNext;
  logic [31:0]    hiReg, hiNext;
  logic [31:0]    loReg, loNext;
  logic           cancelNow;

  logic signed [63:0] sProd;
  logic        [63:0] uProd;
  logic        [63:0] acc;
  logic        [31:0] divisor;
  logic        [31:0] sQuo, sRem, uQuo, uRem;

`ifdef MDU_CANCEL_EN
  assign cancelNow = cancel;
`else
  assign cancelNow = 1'b0;
`endif

  assign sProd = $signed(bus.operandA) * $signed(bus.operandB);
  assign uProd = {32'd0, bus.operandA} * {32'd0, bus.operandB};
  assign acc   = {hiReg, loReg};

  // A zero divisor is replaced so the simulator never evaluates x/0; the zero case is muxed below.
  assign divisor = (bus.operandB == 32'd0) ? 32'd1 : bus.operandB;

  always_comb begin
    sQuo = 32'($signed(bus.operandA) / $signed(divisor));
    sRem = 32'($signed(bus.operandA) % $signed(divisor));
    uQuo = bus.operandA / divisor;
    uRem = bus.operandA % divisor;
    if (bus.operandB == 32'd0) begin
      sQuo = 32'hFFFF_FFFF;
      sRem = bus.operandA;
      uQuo = 32'hFFFF_FFFF;
      uRem = bus.operandA;
    end else if (bus.operandA == 32'h8000_0000 && bus.operandB == 32'hFFFF_FFFF) begin
      sQuo = 32'h8000_0000;
      sRem = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      count   <= '0;
      pending <= '0;
      hiReg   <= '0;
      loReg   <= '0;
    end else begin
      state   <= stateNext;
      count   <= countNext;
      pending <= pendingNext;
      hiReg   <= hiNext;
      loReg   <= loNext;
    end
  end

  // The full 64-bit result is computed at accept; RUN only counts down and then commits it.
  always_comb begin
    stateNext   = state;
    countNext   = count;
    pendingNext = pending;
    hiNext      = hiReg;
    loNext      = loReg;
    case (state)
      IDLE: begin
        if (bus.mulEnable && !cancelNow) begin
          case (bus.mulCtrl)
            MT_SET_HI: hiNext = bus.operandA;
            MT_SET_LO: loNext = bus.operandA;
            MT_MULTIPLY, MT_MULTIPLY_U, MT_MADD, MT_MADDU, MT_MSUB: begin
              stateNext = RUN;
              countNext = MUL_N;
              case (bus.mulCtrl)
                MT_MULTIPLY:   pendingNext = sProd;
                MT_MULTIPLY_U: pendingNext = uProd;
                MT_MADD:       pendingNext = acc + sProd;
                MT_MADDU:      pendingNext = acc + uProd;
                default:       pendingNext = acc - sProd;
              endcase
            end
            MT_DIVIDE, MT_DIVIDE_U: begin
              stateNext   = RUN;
              countNext   = DIV_N;
              pendingNext = (bus.mulCtrl == MT_DIVIDE) ? {sRem, sQuo} : {uRem, uQuo};
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cancelNow) begin
          stateNext   = IDLE;
          countNext   = '0;
          pendingNext = '0;
        end else if (count == CW'(1)) begin
          stateNext = IDLE;
          countNext = '0;
          hiNext    = pending[63:32];
          loNext    = pending[31:0];
        end else begin
          countNext = count - CW'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.busy   = (state == RUN);
  assign bus.hi     = hiReg;
  assign bus.lo     = loReg;
  assign bus.result = bus.mulOutputSel ? hiReg : loReg;

  logic unusedDisabled;
  assign unusedDisabled = (MT_DISABLED == 4'd0);

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: expected {HI,LO} values are queued at issue and popped at commit.
// Define MDU_CANCEL_EN for both bench and RTL to exercise the cancel port.
module tb_mul_div_unit;

  localparam logic [3:0] MT_DISABLED   = 4'd0;
  localparam logic [3:0] MT_MULTIPLY   = 4'd1;
  localparam logic [3:0] MT_MULTIPLY_U = 4'd2;
  localparam logic [3:0] MT_DIVIDE     = 4'd3;
  localparam logic [3:0] MT_DIVIDE_U   = 4'd4;
  localparam logic [3:0] MT_MADD       = 4'd5;
  localparam logic [3:0] MT_MADDU      = 4'd6;
  localparam logic [3:0] MT_MSUB       = 4'd7;
  localparam logic [3:0] MT_SET_HI     = 4'd8;
  localparam logic [3:0] MT_SET_LO     = 4'd9;

  logic clk;
  logic reset_n;
`ifdef MDU_CANCEL_EN
  logic cancel;
`endif

  mul_div_unit_if bus ();

  mul_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef MDU_CANCEL_EN
    .cancel  (cancel),
`endif
    .bus     (bus)
  );

  logic [63:0] sbQ[$];
  logic [63:0] exp64;
  int checkCount = 0;
  int passCount  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic issueOp(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.mulCtrl   = ctrl;
    bus.mulEnable = (ctrl != MT_DISABLED);
    bus.operandA  = a;
    bus.operandB  = b;
    @(posedge clk);
    #1;
    bus.mulCtrl   = MT_DISABLED;
    bus.mulEnable = 1'b0;
  endtask

  // Counts busy cycles from the current point; bounded so a stuck busy cannot hang the run.
  task automatic waitIdle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic runOp(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] expected, output int n);
    sbQ.push_back(expected);
    issueOp(ctrl, a, b);
    waitIdle(n);
  endtask

  task automatic test_reset();
    int n;
    #1;
    checkCount++;
    if ({bus.busy, bus.hi, bus.lo} !== 65'd0) $display("[TB] FAIL reset_initial: got %h expected 0", {bus.busy, bus.hi, bus.lo});
    else passCount++;
    @(negedge clk);
    reset_n = 1'b1;
    issueOp(MT_SET_HI, 32'h0000_1234, 32'd0);
    checkCount++;
    if (bus.hi !== 32'h0000_1234) $display("[TB] FAIL mthi_pre_reset: got %h expected 00001234", bus.hi);
    else passCount++;
    issueOp(MT_MULTIPLY, 32'd3, 32'd5);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkCount++;
    if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy_async: got %b expected 0", bus.busy);
    else passCount++;
    checkCount++;
    if ({bus.hi, bus.lo} !== 64'd0) $display("[TB] FAIL reset_hilo_async: got %h expected 0", {bus.hi, bus.lo});
    else passCount++;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checkCount++;
    if ({bus.busy, bus.hi, bus.lo} !== 65'd0) $display("[TB] FAIL reset_no_commit: got %h expected 0", {bus.busy, bus.hi, bus.lo});
    else passCount++;
    n = 0;
  endtask

  task automatic test_mult();
    int n;
    runOp(MT_MULTIPLY, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, n);
    checkCount++;
    if (n != 5) $display("[TB] FAIL mult_latency: got %0d expected 5", n);
    else passCount++;
    exp64 = sbQ.pop_front();
    checkCount++;
    if ({bus.hi, bus.lo} !== exp64) $display("[TB] FAIL mult_value: got %h expected %h", {bus.hi, bus.lo}, exp64);
    else passCount++;
    runOp(MT_MULTIPLY_U, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA, n);
    checkCount++;
    if (n != 5) $display("[TB] FAIL multu_latency: got %0d expected 5", n);
    else passCount++;
    exp64 = sbQ.pop_front();
    checkCount++;
    if ({bus.hi, bus.lo} !== exp64) $display("[TB] FAIL multu_value: got %h expected %h", {bus.hi, bus.lo}, exp64);
    else passCount++;
  endtask

  task automatic test_div();
    int n;
    runOp(MT_DIVIDE, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, n);
    checkCount++;
    if (n != 10) $display("[TB] FAIL div_latency: got %0d expected 10", n);
    else passCount++;
    exp64 = sbQ.pop_front();
    checkCount++;
    if ({bus.hi, bus.lo} !== exp64) $display("[TB] FAIL div_value: got %h expected %h", {bus.hi, bus.lo}, exp64);
    else passCount++;
    runOp(MT_DIVIDE_U, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF, n);
    exp64 = sbQ.pop_front();
    checkCount++;
    if ({bus.hi, bus.lo} !== exp64) $display("[TB] FAIL divu_by_zero: got %h expected %h", {bus.hi, bus.lo}, exp64);
    else passCount++;
    runOp(MT_DIVIDE, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF, n);
    exp64 = sbQ.pop_front();
    checkCount++;
    if ({bus.hi, bus.lo} !== exp64) $display("[TB] FAIL div_by_zero: got %h expected %h", {bus.hi, bus.lo}, exp64);
    else passCount++;
    runOp(MT_DIVIDE, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, n);
    exp64 = sbQ.pop_front();
    checkCount++;
    if ({bus.hi, bus.lo} !== exp64) $display("[TB] FAIL div_overflow: got %h expected %h", {bus.hi, bus.lo}, exp64);
    else passCount++;
    runOp(MT_DIVIDE_U, 32'hFFFF_FFF9, 32'd2, 64'h0000_0001_7FFF_FFFC, n);
    exp64 = sbQ.pop_front();
    checkCount++;
    if ({bus.hi, bus.lo} !== exp64) $display("[TB] FAIL divu_value: got %h expected %h", {bus.hi, bus.lo}, exp64);
    else passCount++;
  endtask

  task automatic test_accumulate();
    int n;
    issueOp(MT_SET_HI, 32'd1, 32'd0);
    checkCount++;
    if ({bus.busy, bus.hi} !== {1'b0, 32'd1}) $display("[TB] FAIL mthi: got %h expected 000000001", {bus.busy, bus.hi});
    else passCount++;
    issueOp(MT_SET_LO, 32'd0, 32'd0);
    checkCount++;
    if ({bus.busy, bus.lo} !== 33'd0) $display("[TB] FAIL mtlo: got %h expected 0", {bus.busy, bus.lo});
    else passCount++;
    runOp(MT_MADD, 32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF, n);
    checkCount++;
    if (n != 5) $display("[TB] FAIL madd_latency: got %0d expected 5", n);
    else passCount++;
    exp64 = sbQ.pop_front();
    checkCount++;
    if ({bus.hi, bus.lo} !== exp64) $display("[TB] FAIL madd_value: got %h expected %h", {bus.hi, bus.lo}, exp64);
    else passCount++;
    runOp(MT_MSUB, 32'd2, 32'd1, 64'h0000_0000_FFFF_FFFD, n);
    exp64 = sbQ.pop_front();
    checkCount++;
    if ({bus.hi, bus.lo} !== exp64) $display("[TB] FAIL msub_value: got %h expected %h", {bus.hi, bus.lo}, exp64);
    else passCount++;
    runOp(MT_MADDU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0002_FFFF_FFFB, n);
    exp64 = sbQ.pop_front();
    checkCount++;
    if ({bus.hi, bus.lo} !== exp64) $display("[TB] FAIL maddu_value: got %h expected %h", {bus.hi, bus.lo}, exp64);
    else passCount++;
  endtask

  // Commands arriving while busy must vanish; old HI/LO stay readable through result.
  task automatic test_busy_ignore();
    int n;
    sbQ.push_back(64'h0000_0000_0000_000C);
    issueOp(MT_MULTIPLY, 32'd3, 32'd4);
    bus.mulOutputSel = 1'b1;
    #1;
    checkCount++;
    if (bus.result !== 32'd2) $display("[TB] FAIL run_result_hi: got %h expected 00000002", bus.result);
    else passCount++;
    issueOp(MT_MULTIPLY, 32'd100, 32'd100);
    issueOp(MT_SET_LO, 32'h0000_DEAD, 32'd0);
    bus.mulOutputSel = 1'b0;
    #1;
    checkCount++;
    if (bus.result !== 32'hFFFF_FFFB) $display("[TB] FAIL run_result_lo: got %h expected fffffffb", bus.result);
    else passCount++;
    waitIdle(n);
    checkCount++;
    if (n != 3) $display("[TB] FAIL busy_remaining: got %0d expected 3", n);
    else passCount++;
    exp64 = sbQ.pop_front();
    checkCount++;
    if ({bus.hi, bus.lo} !== exp64) $display("[TB] FAIL busy_ignore_value: got %h expected %h", {bus.hi, bus.lo}, exp64);
    else passCount++;
    repeat (6) @(posedge clk);
    #1;
    checkCount++;
    if ({bus.busy, bus.hi, bus.lo} !== {1'b0, exp64}) $display("[TB] FAIL busy_ignore_after: got %h expected %h", {bus.busy, bus.hi, bus.lo}, {1'b0, exp64});
    else passCount++;
  endtask

`ifdef MDU_CANCEL_EN
  task automatic test_cancel();
    int n;
    logic [63:0] before;
    before = {bus.hi, bus.lo};
    issueOp(MT_DIVIDE, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    checkCount++;
    if ({bus.busy, bus.hi, bus.lo} !== {1'b0, before}) $display("[TB] FAIL cancel_mid: got %h expected %h", {bus.busy, bus.hi, bus.lo}, {1'b0, before});
    else passCount++;
    issueOp(MT_DIVIDE, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkCount++;
    if ({bus.busy, bus.hi, bus.lo} !== {1'b0, before}) $display("[TB] FAIL cancel_commit: got %h expected %h", {bus.busy, bus.hi, bus.lo}, {1'b0, before});
    else passCount++;
    cancel = 1'b1;
    issueOp(MT_SET_HI, 32'h0000_0055, 32'd0);
    cancel = 1'b0;
    checkCount++;
    if (bus.hi !== before[63:32]) $display("[TB] FAIL cancel_idle: got %h expected %h", bus.hi, before[63:32]);
    else passCount++;
    runOp(MT_MULTIPLY, 32'd2, 32'd3, 64'h0000_0000_0000_0006, n);
    exp64 = sbQ.pop_front();
    checkCount++;
    if ({bus.hi, bus.lo} !== exp64) $display("[TB] FAIL after_cancel: got %h expected %h", {bus.hi, bus.lo}, exp64);
    else passCount++;
  endtask
`endif

  initial begin
    reset_n          = 1'b0;
    bus.mulCtrl      = MT_DISABLED;
    bus.mulEnable    = 1'b0;
    bus.operandA     = 32'd0;
    bus.operandB     = 32'd0;
    bus.mulOutputSel = 1'b0;
`ifdef MDU_CANCEL_EN
    cancel           = 1'b0;
`endif
    test_reset();
    test_mult();
    test_div();
    test_accumulate();
    test_busy_ignore();
`ifdef MDU_CANCEL_EN
    test_cancel();
`endif
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
